reciprocal_sched: RTL and testbench

Round-robin scheduler that shares one iterative `reciprocal` unit between `NREQ` requesters. It performs these steps:
- accepts per-requester operand requests
- screens out operands the unit cannot handle
- sequences the unit's 4-phase `req`/`ack` handshake
- returns the 2W-bit result to the winning requester with a one-cycle `done` pulse

It sits between client datapaths and the single `reciprocal #(W)` instance.

---
 rtl/reciprocal_sched_pkg.sv | 20 ++
 rtl/reciprocal_sched_if.sv | 33 +++
 rtl/reciprocal_sched_rr_pick.sv | 25 ++
 rtl/reciprocal_sched.sv | 129 ++++++++++++
 tb/tb_reciprocal_sched.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/reciprocal_sched_pkg.sv
// Shared types for the reciprocal scheduler: FSM state encoding and the
// operand record a requester presents to the reciprocal unit.
package reciprocal_pkg;

  localparam int DEF_W  = 8;
  localparam int DEF_IW = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RELEASE,
    DONE
  } sched_state_t;

  typedef struct packed {
    logic [DEF_W-1:0]  a;
    logic [DEF_IW-1:0] n_iter;
  } operand_t;

endpackage

// File: rtl/reciprocal_sched_if.sv
// Bundle of client-side request/done signals and the reciprocal unit
// req/ack handshake. slave is the scheduler's view, master the environment's.
interface reciprocal_sched_if #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IW   = 4
);

  logic [NREQ-1:0]         req;
  logic [NREQ-1:0][W-1:0]  a_in;
  logic [NREQ-1:0][IW-1:0] n_iter_in;
  logic [NREQ-1:0]         done;
  logic [2*W-1:0]          p_out;
  logic                    err;
  logic                    busy;

  logic                    rcp_req;
  logic [W-1:0]            rcp_a;
  logic [IW-1:0]           rcp_n_iter;
  logic [2*W-1:0]          rcp_p;
  logic                    rcp_ack;

  modport master (
    output req, a_in, n_iter_in, rcp_p, rcp_ack,
    input  done, p_out, err, busy, rcp_req, rcp_a, rcp_n_iter
  );

  modport slave (
    input  req, a_in, n_iter_in, rcp_p, rcp_ack,
    output done, p_out, err, busy, rcp_req, rcp_a, rcp_n_iter
  );

endinterface

// File: rtl/reciprocal_sched_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr,
// wrapping around. gnt_idx is only meaningful when any is high.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   gnt_idx,
  output logic            any
);

  // Scan from the farthest offset down so the closest one to ptr wins.
  always_comb begin
    gnt_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % NREQ]) begin
        gnt_idx = PW'((int'(ptr) + i) % NREQ);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/reciprocal_sched.sv
// Round-robin scheduler sharing one iterative reciprocal unit between NREQ
// requesters, with operand screening and a bounded wait for the unit's ack.
module reciprocal_sched
  import reciprocal_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int W       = DEF_W,
  parameter int IW      = DEF_IW,
  parameter int TIMEOUT = 255
) (
  input logic               clock,
  input logic               reset_n,
  reciprocal_sched_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [PW-1:0]   LAST_IDX = PW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_HOT  = NREQ'(1);

  sched_state_t   state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [PW-1:0]  gnt_q, gnt_d;
  logic [W-1:0]   a_q, a_d;
  logic [IW-1:0]  nIter_q, nIter_d;
  logic [CW-1:0]  waitCnt_q, waitCnt_d;
  logic [2*W-1:0] p_q, p_d;
  logic           err_q, err_d;

  logic [PW-1:0]  pickIdx;
  logic           pickAny;

  rr_pick #(.NREQ(NREQ), .PW(PW)) uPick (
    .req     (bus.req),
    .ptr     (ptr_q),
    .gnt_idx (pickIdx),
    .any     (pickAny)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      a_q       <= '0;
      nIter_q   <= '0;
      waitCnt_q <= '0;
      p_q       <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      a_q       <= a_d;
      nIter_q   <= nIter_d;
      waitCnt_q <= waitCnt_d;
      p_q       <= p_d;
      err_q     <= err_d;
    end
  end

  // A still-high rcp_ack in IDLE means the unit hasn't finished its 4-phase
  // cycle (e.g. after a reset mid-operation), so no new grant is made.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    a_d       = a_q;
    nIter_d   = nIter_q;
    waitCnt_d = waitCnt_q;
    p_d       = p_q;
    err_d     = err_q;

    unique case (state_q)
      IDLE: begin
        if (!bus.rcp_ack && pickAny) begin
          gnt_d     = pickIdx;
          a_d       = bus.a_in[pickIdx];
          nIter_d   = bus.n_iter_in[pickIdx];
          waitCnt_d = '0;
          if (!bus.a_in[pickIdx][W-1] || (bus.n_iter_in[pickIdx] == '0)) begin
            err_d   = 1'b1;
            p_d     = '1;
            state_d = DONE;
          end else begin
            state_d = ISSUE;
          end
        end
      end

      ISSUE: begin
        if (bus.rcp_ack) begin
          p_d     = bus.rcp_p;
          err_d   = 1'b0;
          state_d = RELEASE;
        end else if (waitCnt_q == CNT_LAST) begin
          p_d     = '1;
          err_d   = 1'b1;
          state_d = RELEASE;
        end else begin
          waitCnt_d = waitCnt_q + CW'(1);
        end
      end

      RELEASE: begin
        if (!bus.rcp_ack) begin
          state_d = DONE;
        end
      end

      DONE: begin
        ptr_d   = (gnt_q == LAST_IDX) ? '0 : gnt_q + PW'(1);
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.rcp_req    = (state_q == ISSUE);
  assign bus.rcp_a      = a_q;
  assign bus.rcp_n_iter = nIter_q;
  assign bus.p_out      = p_q;
  assign bus.err        = err_q;
  assign bus.done       = (state_q == DONE) ? (ONE_HOT << gnt_q) : '0;

endmodule

// File: tb/tb_reciprocal_sched.sv
// Scoreboard bench for reciprocal_sched with a stub reciprocal unit that acks
// 10 cycles after req and returns 16'h0123 + A.
module tb_reciprocal_sched;
  import reciprocal_pkg::*;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  reciprocal_sched_if #(.NREQ(4), .W(8), .IW(4)) bus ();

  reciprocal_sched #(.NREQ(4), .W(8), .IW(4), .TIMEOUT(255)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int          idx;
    logic [15:0] p;
    logic        err;
  } exp_t;

  exp_t sbQ[$];
  int   errors = 0;
  int   checks = 0;

  logic        forceAck = 1'b0;
  logic        noAck    = 1'b0;
  logic        stubAck  = 1'b0;
  logic [15:0] stubP    = '0;
  int          stubCnt  = 0;

  int         runLen  = 0;
  int         lastRun = 0;
  int         rises   = 0;
  logic       prevReq = 1'b0;
  logic       aStable = 1'b1;
  logic [7:0] runA    = '0;

  assign bus.rcp_ack = stubAck;
  assign bus.rcp_p   = stubP;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input operand_t op);
    bus.a_in[idx]      = op.a;
    bus.n_iter_in[idx] = op.n_iter;
  endtask

  task automatic waitDones(input int n, input int budget, input string name,
                           input logic [3:0] dropMask);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < budget) begin
      @(negedge clock);
      cyc++;
      if (|bus.done) got++;
    end
    bus.req = bus.req & ~dropMask;
    checkOutput(name, got, n);
  endtask

  task automatic waitRcpReq(input int budget, input string name, output int cyc);
    cyc = 0;
    while (!bus.rcp_req && cyc < budget) begin
      @(negedge clock);
      cyc++;
    end
    checkOutput(name, 32'(bus.rcp_req), 1);
  endtask

  // Stub unit: ack 10 cycles into req, drop ack one cycle after req falls.
  always @(posedge clock) begin
    if (forceAck) begin
      stubAck <= 1'b1;
      stubCnt <= 0;
    end else if (!bus.rcp_req) begin
      stubAck <= 1'b0;
      stubCnt <= 0;
    end else if (!noAck && !stubAck) begin
      if (stubCnt == 9) begin
        stubAck <= 1'b1;
        stubP   <= 16'h0123 + {8'h00, bus.rcp_a};
      end else begin
        stubCnt <= stubCnt + 1;
      end
    end
  end

  // Monitor: pops the scoreboard on every done and tracks rcp_req runs.
  always @(negedge clock) begin
    exp_t e;
    if (reset_n && (|bus.done)) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_done", 32'(bus.done), 0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("done_onehot", 32'(bus.done), 32'(4'b0001 << e.idx));
        checkOutput("p_out", 32'(bus.p_out), 32'(e.p));
        checkOutput("err", 32'(bus.err), 32'(e.err));
      end
    end
    if (bus.rcp_req) begin
      if (!prevReq) begin
        rises++;
        runA    = bus.rcp_a;
        aStable = 1'b1;
        runLen  = 0;
      end else if (bus.rcp_a !== runA) begin
        aStable = 1'b0;
      end
      runLen++;
    end else if (prevReq) begin
      lastRun = runLen;
      checkOutput("rcp_a_stable", 32'(aStable), 1);
    end
    prevReq = bus.rcp_req;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    int r0;
    bus.req       = '0;
    bus.a_in      = '0;
    bus.n_iter_in = '0;
    reset_n       = 1'b0;
    repeat (3) @(negedge clock);

    checkOutput("rst_done", 32'(bus.done), 0);
    checkOutput("rst_p_out", 32'(bus.p_out), 0);
    checkOutput("rst_err", 32'(bus.err), 0);
    checkOutput("rst_busy", 32'(bus.busy), 0);
    checkOutput("rst_rcp_req", 32'(bus.rcp_req), 0);
    checkOutput("rst_rcp_a", 32'(bus.rcp_a), 0);
    checkOutput("rst_rcp_n_iter", 32'(bus.rcp_n_iter), 0);
    reset_n = 1'b1;
    @(negedge clock);

    $display("[TB] fairness: all four requesting");
    applyStimulus(0, '{a: 8'hF7, n_iter: 4'd6});
    applyStimulus(1, '{a: 8'h94, n_iter: 4'd6});
    applyStimulus(2, '{a: 8'hA0, n_iter: 4'd6});
    applyStimulus(3, '{a: 8'hC0, n_iter: 4'd6});
    sbQ.push_back('{0, 16'h021A, 1'b0});
    sbQ.push_back('{1, 16'h01B7, 1'b0});
    sbQ.push_back('{2, 16'h01C3, 1'b0});
    sbQ.push_back('{3, 16'h01E3, 1'b0});
    sbQ.push_back('{0, 16'h021A, 1'b0});
    bus.req = 4'b1111;
    waitDones(5, 300, "fair_done_count", 4'b1111);
    @(negedge clock);

    $display("[TB] single request on requester 0");
    applyStimulus(0, '{a: 8'hE1, n_iter: 4'd8});
    sbQ.push_back('{0, 16'h0204, 1'b0});
    bus.req = 4'b0001;
    waitRcpReq(20, "single_rcp_req_rise", cyc);
    checkOutput("single_issue_latency", cyc, 1);
    checkOutput("single_rcp_a", 32'(bus.rcp_a), 32'h0000_00E1);
    checkOutput("single_rcp_n_iter", 32'(bus.rcp_n_iter), 8);
    waitDones(1, 60, "single_done_count", 4'b0001);
    @(negedge clock);
    checkOutput("single_p_held", 32'(bus.p_out), 32'h0000_0204);
    checkOutput("single_busy_idle", 32'(bus.busy), 0);

    $display("[TB] rejection: unnormalized operand, then zero iterations");
    applyStimulus(2, '{a: 8'h40, n_iter: 4'd8});
    sbQ.push_back('{2, 16'hFFFF, 1'b1});
    r0 = rises;
    bus.req = 4'b0100;
    @(negedge clock);
    checkOutput("rej_a_latency", 32'(bus.done), 32'h4);
    bus.req = 4'b0000;
    checkOutput("rej_a_no_rcp_req", rises, r0);
    @(negedge clock);
    applyStimulus(2, '{a: 8'hC0, n_iter: 4'd0});
    sbQ.push_back('{2, 16'hFFFF, 1'b1});
    bus.req = 4'b0100;
    @(negedge clock);
    checkOutput("rej_n_latency", 32'(bus.done), 32'h4);
    bus.req = 4'b0000;
    checkOutput("rej_n_no_rcp_req", rises, r0);
    @(negedge clock);

    $display("[TB] timeout: unit never acknowledges");
    noAck = 1'b1;
    applyStimulus(1, '{a: 8'h80, n_iter: 4'd3});
    sbQ.push_back('{1, 16'hFFFF, 1'b1});
    bus.req = 4'b0010;
    waitDones(1, 400, "timeout_done_count", 4'b0010);
    checkOutput("timeout_rcp_req_cycles", lastRun, 255);
    noAck = 1'b0;
    @(negedge clock);

    $display("[TB] reset during ISSUE with ack held high afterwards");
    applyStimulus(0, '{a: 8'h81, n_iter: 4'd5});
    bus.req = 4'b0001;
    waitRcpReq(20, "rst_mid_rcp_req_rise", cyc);
    repeat (4) @(negedge clock);
    forceAck = 1'b1;
    reset_n  = 1'b0;
    @(negedge clock);
    checkOutput("rst_mid_done", 32'(bus.done), 0);
    checkOutput("rst_mid_p_out", 32'(bus.p_out), 0);
    checkOutput("rst_mid_err", 32'(bus.err), 0);
    checkOutput("rst_mid_busy", 32'(bus.busy), 0);
    checkOutput("rst_mid_rcp_req", 32'(bus.rcp_req), 0);
    checkOutput("rst_mid_rcp_a", 32'(bus.rcp_a), 0);
    checkOutput("rst_mid_rcp_n_iter", 32'(bus.rcp_n_iter), 0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("rst_mid_blocked_by_ack", 32'(bus.rcp_req), 0);
    end
    forceAck = 1'b0;
    sbQ.push_back('{0, 16'h01A4, 1'b0});
    waitDones(1, 60, "rst_mid_resume_done_count", 4'b0001);
    @(negedge clock);

    $display("[TB] early drop of req while granted");
    applyStimulus(3, '{a: 8'hB3, n_iter: 4'd2});
    sbQ.push_back('{3, 16'h01D6, 1'b0});
    bus.req = 4'b1000;
    waitRcpReq(20, "drop_rcp_req_rise", cyc);
    repeat (2) @(negedge clock);
    bus.req = 4'b0000;
    waitDones(1, 60, "drop_done_count", 4'b0000);

    repeat (3) @(negedge clock);
    checkOutput("scoreboard_empty", sbQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
